// File: rtl/wm8731_reg_target.sv
`timescale 1ns/1ps
// I2C write-only register target modelled on the WM8731 control port:
// 7-bit register address + 9-bit data per byte pair, ten-entry register file.
//
// state  | meaning
// IDLE   | bus idle or after STOP, waiting for START
// ADDR   | shifting device address and R/W bit
// ACK_A  | acknowledging the address byte
// BYTE1  | shifting first byte (reg addr + data MSB)
// ACK_1  | acknowledging byte 1
// BYTE2  | shifting second byte, commit on its last bit
// ACK_2  | acknowledging byte 2, then back to BYTE1
// IGNORE | not addressed (or read), wait for START/STOP
module wm8731_reg_target #(
  parameter logic [6:0] DEV_ADDR = 7'h1A,
  parameter int         FILT     = 2
) (
  input  logic       MCLK,
  input  logic       RESET,
  input  logic       SCL,
  input  logic       SDA_IN,
  output logic       SDA_OE,
  output logic       WR_STB,
  output logic [6:0] WR_ADDR,
  output logic [8:0] WR_DATA,
  output logic       SW_RST,
  input  logic [3:0] RD_ADDR,
  output logic [8:0] RD_DATA,
  output logic       ACTIVE
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ACK_A, BYTE1, ACK_1, BYTE2, ACK_2, IGNORE
  } state_t;

  state_t state, state_n;

  logic [FILT-1:0] scl_sync, sda_sync;
  logic            scl_s, sda_s, scl_d, sda_d;
  logic            scl_rise, scl_fall, start, stop;

  logic [2:0]  bit_cnt, cnt_n;
  logic [7:0]  shift, shift_n, byte1, byte1_n, bit_in;
  logic        ack_on, ack_on_n, oe_n, commit;
  logic [15:0] wr_word;
  logic [8:0]  regs [10];

  function automatic logic [8:0] reg_default(input int idx);
    case (idx)
      0, 1:    return 9'h097;
      2, 3:    return 9'h079;
      4:       return 9'h00A;
      5:       return 9'h008;
      6:       return 9'h09F;
      7:       return 9'h00A;
      default: return 9'h000;
    endcase
  endfunction

  // Synchronizers idle high so a reset never looks like a bus event.
  always_ff @(posedge MCLK or negedge RESET) begin
    if (!RESET) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync[0] <= SCL;
      sda_sync[0] <= SDA_IN;
      for (int i = 1; i < FILT; i++) begin
        scl_sync[i] <= scl_sync[i-1];
        sda_sync[i] <= sda_sync[i-1];
      end
      scl_d <= scl_s;
      sda_d <= sda_s;
    end
  end

  assign scl_s    = scl_sync[FILT-1];
  assign sda_s    = sda_sync[FILT-1];
  assign scl_rise = scl_s & ~scl_d;
  assign scl_fall = ~scl_s & scl_d;
  assign start    = scl_s & sda_d & ~sda_s;
  assign stop     = scl_s & ~sda_d & sda_s;
  assign bit_in   = {shift[6:0], sda_s};
  assign wr_word  = {byte1, bit_in};

  always_comb begin
    state_n  = state;
    cnt_n    = bit_cnt;
    shift_n  = shift;
    byte1_n  = byte1;
    ack_on_n = ack_on;
    oe_n     = SDA_OE;
    commit   = 1'b0;
    if (start || stop) begin
      state_n  = start ? ADDR : IDLE;
      cnt_n    = 3'd0;
      ack_on_n = 1'b0;
      oe_n     = 1'b0;
    end else begin
      case (state)
        ADDR, BYTE1, BYTE2: begin
          if (scl_rise) begin
            shift_n = bit_in;
            cnt_n   = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              if (state == ADDR) begin
                state_n = (bit_in == {DEV_ADDR, 1'b0}) ? ACK_A : IGNORE;
              end else if (state == BYTE1) begin
                byte1_n = bit_in;
                state_n = ACK_1;
              end else begin
                commit  = 1'b1;
                state_n = ACK_2;
              end
            end
          end
        end
        ACK_A, ACK_1, ACK_2: begin
          if (scl_fall) begin
            if (!ack_on) begin
              oe_n     = 1'b1;
              ack_on_n = 1'b1;
            end else begin
              oe_n     = 1'b0;
              ack_on_n = 1'b0;
              state_n  = (state == ACK_1) ? BYTE2 : BYTE1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge MCLK or negedge RESET) begin
    if (!RESET) begin
      state   <= IDLE;
      bit_cnt <= 3'd0;
      shift   <= 8'h00;
      byte1   <= 8'h00;
      ack_on  <= 1'b0;
      SDA_OE  <= 1'b0;
      WR_STB  <= 1'b0;
      SW_RST  <= 1'b0;
      WR_ADDR <= 7'h00;
      WR_DATA <= 9'h000;
    end else begin
      state   <= state_n;
      bit_cnt <= cnt_n;
      shift   <= shift_n;
      byte1   <= byte1_n;
      ack_on  <= ack_on_n;
      SDA_OE  <= oe_n;
      WR_STB  <= commit;
      SW_RST  <= commit && (wr_word[15:9] == 7'h0F);
      if (commit) begin
        WR_ADDR <= wr_word[15:9];
        WR_DATA <= wr_word[8:0];
      end
    end
  end

  // Address 0x0F is the software reset; 0x0A..0x0E and above 0x0F are accepted but dropped.
  always_ff @(posedge MCLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < 10; i++) regs[i] <= reg_default(i);
    end else if (commit) begin
      if (wr_word[15:9] == 7'h0F) begin
        for (int i = 0; i < 10; i++) regs[i] <= reg_default(i);
      end else begin
        for (int i = 0; i < 10; i++)
          if (wr_word[15:9] == 7'(i)) regs[i] <= wr_word[8:0];
      end
    end
  end

  always_comb begin
    RD_DATA = 9'h000;
    for (int i = 0; i < 10; i++)
      if (RD_ADDR == 4'(i)) RD_DATA = regs[i];
  end

  assign ACTIVE = regs[9][0];

endmodule

// File: tb/tb_wm8731_reg_target.sv
`timescale 1ns/1ps
// Bench for wm8731_reg_target: bit-banged I2C master, register-file model
// computed from address/data arithmetic, directed cases then random writes.
module tb_wm8731_reg_target;
  localparam int FILT  = 2;
  localparam int CLK_P = 20;
  localparam int Q     = 4;
  localparam int H     = 8;
  localparam logic [8:0] DEF [10] = '{9'h097, 9'h097, 9'h079, 9'h079, 9'h00A,
                                      9'h008, 9'h09F, 9'h00A, 9'h000, 9'h000};

  logic       MCLK = 1'b0;
  logic       RESET = 1'b0;
  logic       SCL = 1'b1;
  logic       sda_drv = 1'b1;
  logic [3:0] RD_ADDR = 4'd0;
  logic       SDA_IN, SDA_OE, WR_STB, SW_RST, ACTIVE;
  logic [6:0] WR_ADDR;
  logic [8:0] WR_DATA, RD_DATA;

  assign SDA_IN = sda_drv & ~SDA_OE;

  wm8731_reg_target #(.DEV_ADDR(7'h1A), .FILT(FILT)) dut (
    .MCLK(MCLK), .RESET(RESET), .SCL(SCL), .SDA_IN(SDA_IN), .SDA_OE(SDA_OE),
    .WR_STB(WR_STB), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA), .SW_RST(SW_RST),
    .RD_ADDR(RD_ADDR), .RD_DATA(RD_DATA), .ACTIVE(ACTIVE)
  );

  always #(CLK_P/2) MCLK = ~MCLK;

  int vectors = 0, miscompares = 0;
  int stb_cnt = 0, oe_cnt = 0, sw_cnt = 0;
  longint stb_lat = 0, rise_t = 0;
  logic [8:0] model [10];
  int exp_stb = 0;
  logic [6:0] last_a = 7'h00;
  logic [8:0] last_d = 9'h000;

  always @(negedge MCLK) begin
    if (WR_STB) begin
      stb_cnt = stb_cnt + 1;
      stb_lat = (longint'($time) - rise_t) / CLK_P;
    end
    if (SDA_OE) oe_cnt = oe_cnt + 1;
    if (SW_RST) sw_cnt = sw_cnt + 1;
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic w(input int n);
    repeat (n) @(negedge MCLK);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    sda_drv = b; w(Q);
    SCL = 1'b1; rise_t = longint'($time); w(H);
    SCL = 1'b0; w(Q);
  endtask

  task automatic send_bits(input logic [7:0] v, input int n);
    for (int i = 7; i > 7 - n; i--) send_bit(v[i]);
  endtask

  task automatic write_byte(input logic [7:0] v, input logic exp_ack, input string tag);
    logic ack;
    send_bits(v, 8);
    sda_drv = 1'b1; w(Q);
    SCL = 1'b1; w(H/2);
    ack = SDA_OE; w(H/2);
    SCL = 1'b0; w(Q);
    check(tag, 32'(ack), 32'(exp_ack));
  endtask

  task automatic i2c_start();
    sda_drv = 1'b1; w(Q);
    SCL = 1'b1; w(Q);
    sda_drv = 1'b0; w(Q);
    SCL = 1'b0; w(Q);
  endtask

  task automatic i2c_stop();
    sda_drv = 1'b0; w(Q);
    SCL = 1'b1; w(Q);
    sda_drv = 1'b1; w(Q);
  endtask

  task automatic model_defaults();
    for (int i = 0; i < 10; i++) model[i] = DEF[i];
  endtask

  // Encode one register write as the two bus bytes and update the model.
  task automatic wr_pair(input int addr, input int data, input string tag);
    int word;
    word = addr * 512 + data;
    write_byte(8'(word / 256), 1'b1, {tag, "_b1"});
    write_byte(8'(word % 256), 1'b1, {tag, "_b2"});
    if (addr < 10) model[addr] = 9'(data);
    else if (addr == 15) model_defaults();
    exp_stb++;
    last_a = 7'(addr);
    last_d = 9'(data);
  endtask

  task automatic compare_regs(input string tag);
    for (int i = 0; i < 16; i++) begin
      RD_ADDR = 4'(i); #1;
      check($sformatf("%s_rd%0d", tag, i), 32'(RD_DATA), (i < 10) ? 32'(model[i]) : 32'd0);
    end
    check({tag, "_active"}, 32'(ACTIVE), 32'(model[9][0]));
  endtask

  task automatic check_tx(input string tag);
    w(4);
    compare_regs(tag);
    check({tag, "_stbcnt"}, 32'(stb_cnt), 32'(exp_stb));
    check({tag, "_wraddr"}, 32'(WR_ADDR), 32'(last_a));
    check({tag, "_wrdata"}, 32'(WR_DATA), 32'(last_d));
  endtask

  initial begin
    int oe0, sw0, np, r, addr, data;
    model_defaults();
    w(3);
    check("rst_oe", 32'(SDA_OE), 0);
    check("rst_stb", 32'(WR_STB), 0);
    check("rst_swrst", 32'(SW_RST), 0);
    check("rst_wraddr", 32'(WR_ADDR), 0);
    check("rst_wrdata", 32'(WR_DATA), 0);
    compare_regs("rst");
    RESET = 1'b1; w(4);

    // write R9 = 1 (ACTIVE), with strobe latency check
    i2c_start(); write_byte(8'h34, 1'b1, "t33_addr");
    wr_pair(9, 9'h001, "t33"); i2c_stop();
    check_tx("t33");
    check("t33_latency", 32'(stb_lat), 32'(FILT + 1));

    // wrong device address
    oe0 = oe_cnt;
    i2c_start(); write_byte(8'h36, 1'b0, "t34_addr");
    write_byte(8'h00, 1'b0, "t34_b1"); write_byte(8'h00, 1'b0, "t34_b2"); i2c_stop();
    check("t34_oe", 32'(oe_cnt), 32'(oe0));
    check_tx("t34");

    // software reset via register 0x0F
    i2c_start(); write_byte(8'h34, 1'b1, "t35_addr");
    wr_pair(4, 9'h012, "t35a"); i2c_stop();
    check_tx("t35a");
    sw0 = sw_cnt;
    i2c_start(); write_byte(8'h34, 1'b1, "t35_addr2");
    wr_pair(15, 0, "t35b"); i2c_stop();
    check_tx("t35b");
    check("t35_swrst", 32'(sw_cnt), 32'(sw0 + 1));

    // read request is NACKed and ignored
    oe0 = oe_cnt;
    i2c_start(); write_byte(8'h35, 1'b0, "t36_addr");
    write_byte(8'h12, 1'b0, "t36_b1"); write_byte(8'h01, 1'b0, "t36_b2");
    check("t36_nostb", 32'(stb_cnt), 32'(exp_stb));
    i2c_stop();
    check("t36_oe", 32'(oe_cnt), 32'(oe0));
    check_tx("t36");

    // repeated start mid second byte discards partial pair
    i2c_start(); write_byte(8'h34, 1'b1, "t37_addr");
    write_byte(8'h0E, 1'b1, "t37_p1"); send_bits(8'h51, 4);
    i2c_start(); write_byte(8'h34, 1'b1, "t37_addr2");
    wr_pair(7, 9'h051, "t37"); i2c_stop();
    check_tx("t37");

    // STOP in the middle of the second byte aborts the pair
    i2c_start(); write_byte(8'h34, 1'b1, "abort_addr");
    write_byte(8'h0E, 1'b1, "abort_b1"); send_bits(8'h51, 5); i2c_stop();
    check_tx("abort");

    // unmapped addresses, consecutive pairs in one transfer
    i2c_start(); write_byte(8'h34, 1'b1, "unm_addr");
    wr_pair(10, 9'h1AB, "unm1"); wr_pair(13, 9'h055, "unm2"); wr_pair(3, 9'h100, "unm3");
    i2c_stop();
    check_tx("unm");

    for (int t = 0; t < 20; t++) begin
      i2c_start(); write_byte(8'h34, 1'b1, "rnd_addr");
      np = $urandom_range(1, 3);
      for (int p = 0; p < np; p++) begin
        r = $urandom_range(0, 19);
        addr = (r <= 9) ? r : (r <= 11) ? 15 : r - 2;
        data = $urandom_range(0, 511);
        wr_pair(addr, data, $sformatf("rnd%0d_%0d", t, p));
      end
      i2c_stop();
      check_tx($sformatf("rnd%0d", t));
    end

    // set non-default state, then reset during the ACK_1 low pulse
    i2c_start(); write_byte(8'h34, 1'b1, "pre_addr");
    wr_pair(9, 9'h1F1, "pre9"); wr_pair(0, 9'h155, "pre0"); i2c_stop();
    check_tx("pre");
    i2c_start(); write_byte(8'h34, 1'b1, "t38_addr");
    send_bits(8'h12, 8); sda_drv = 1'b1;
    for (int i = 0; i < 200 && !SDA_OE; i++) @(negedge MCLK);
    check("t38_ack_on", 32'(SDA_OE), 1);
    #3 RESET = 1'b0;
    #1;
    check("t38_oe_async", 32'(SDA_OE), 0);
    check("t38_stb", 32'(WR_STB), 0);
    check("t38_swrst", 32'(SW_RST), 0);
    model_defaults(); last_a = 7'h00; last_d = 9'h000;
    check("t38_wraddr", 32'(WR_ADDR), 0);
    check("t38_wrdata", 32'(WR_DATA), 0);
    compare_regs("t38_inrst");
    SCL = 1'b1; sda_drv = 1'b1; w(3);
    RESET = 1'b1; w(4);

    // bus traffic without a START is ignored
    oe0 = oe_cnt;
    SCL = 1'b0; w(Q);
    for (int i = 0; i < 27; i++) send_bit(1'($urandom_range(0, 1)));
    check("post_oe", 32'(oe_cnt), 32'(oe0));
    check_tx("post_idle");
    i2c_start(); write_byte(8'h34, 1'b1, "post_addr");
    wr_pair(2, 9'h1FF, "post"); i2c_stop();
    check_tx("post");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
